// File: rtl/neuron_mac.sv
// ============================================================================
// Module   : neuron_mac
// Purpose  : Sequential Q8.8 multiply-accumulate neuron with bias, saturation
//            and optional ReLU (enable with `define NEURON_RELU_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_mac #(
    parameter int N_IN   = 3,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] bias,
    output logic        [1:0]        sel,
    output logic        [DATA_W-1:0] y,
    output logic                     done,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW = 2*DATA_W + 2;
    localparam logic [1:0] c_N_IN = 2'(N_IN);
    localparam logic signed [AW-1:0] c_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] c_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_ACT  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                     r_state;
    logic        [1:0]          r_cnt;
    logic signed [AW-1:0]       r_acc;
    logic signed [DATA_W-1:0]   r_bias;
    logic        [DATA_W-1:0]   r_y;
    logic                       r_overrun;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [AW-1:0]       w_prod_ext;
    logic signed [AW-1:0]       w_bias_ext;
    logic signed [AW-1:0]       w_sum_full;
    logic signed [AW-1:0]       w_sum;
    logic signed [DATA_W-1:0]   w_sat;
    logic        [DATA_W-1:0]   w_act;

    assign w_prod     = x * w;
    assign w_prod_ext = {{2{w_prod[2*DATA_W-1]}}, w_prod};
    // Bias is aligned to the Q16.16 product scale before the common shift.
    assign w_bias_ext = {{(AW-DATA_W-FRAC){r_bias[DATA_W-1]}}, r_bias, {FRAC{1'b0}}};
    assign w_sum_full = r_acc + w_bias_ext;
    assign w_sum      = w_sum_full >>> FRAC;

    always_comb begin
        w_sat = w_sum[DATA_W-1:0];
        if (w_sum > c_MAX) begin
            w_sat = c_MAX[DATA_W-1:0];
        end else if (w_sum < c_MIN) begin
            w_sat = c_MIN[DATA_W-1:0];
        end
    end

`ifdef NEURON_RELU_EN
    assign w_act = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    assign w_act = w_sat;
`endif

    assign sel     = (r_state == S_MAC) ? r_cnt : 2'd0;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_OUT);
    assign y       = r_y;
    assign overrun = r_overrun;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_acc     <= '0;
            r_bias    <= '0;
            r_y       <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (ready && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    if (ready) begin
                        r_bias  <= bias;
                        r_cnt   <= 2'd1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_cnt == c_N_IN) begin
                        r_state <= S_ACT;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_ACT: begin
                    r_y     <= w_act;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_acc   <= '0;
                    r_cnt   <= 2'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron that sits directly downstream of the three-input operand buffer. On the buffer's `ready` pulse it steps the buffer's `sel` through inputs 1..N. It consumes one muxed (`x`, `w`) pair per cycle, accumulates signed Q8.8 products plus a bias, then applies saturation and optional ReLU. The registered result and a one-cycle `done` pulse feed the next layer's buffer as one of its `xK`/`doneK` pairs.

## Interface
- `N_IN`, 3: number of inputs sequenced per activation. `sel` is 2 bits, so 1..3 is legal.
- `DATA_W`, 16: operand/result width, signed two's complement.
- `FRAC`, 8: fractional bits (Q8.8).
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `ready` input 1: buffer "all operands latched" pulse.
- `x` input DATA_W: muxed activation from buffer.
- `w` input DATA_W: muxed weight from buffer.
- `bias` input DATA_W: neuron bias, Q8.8.
- `sel` output 2: operand select to buffer; 0 = none.
- `y` output DATA_W: registered neuron output.
- `done` output 1: one-cycle pulse, `y` updated.
- `busy` output 1: high in any state other than IDLE.
- `overrun` output 1: sticky; set when `ready` arrives while busy.

## Operation
- States: IDLE, MAC, ACT, OUT.
- IDLE: `sel`=0, `acc`=0.
  - On `ready`=1, capture `bias` into `bias_r`, set `cnt`=1, and go to MAC.
- MAC: `sel`=`cnt` (combinational from the state register).
  - Each cycle: `acc` <= `acc` + sign-extended(`x`*`w`).
  - The product is a full 2*DATA_W signed value.
  - `acc` is 2*DATA_W+2 bits signed, so it never wraps for N_IN ≤ 3.
  - If `cnt`==N_IN, go to ACT; otherwise `cnt`++.
- ACT: `sel`=0.
  - `sum` = (`acc` + (sign-ext `bias_r` <<< FRAC)) >>> FRAC. The shift is arithmetic, so the result is floor-rounded.
  - Saturate `sum` to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Apply the optional ReLU (see Configuration).
  - Register the result into `y` and go to OUT.
- OUT: `done`=1 for exactly this cycle. Clear `acc`, then go to IDLE.
- `ready` seen in MAC, ACT or OUT:
  - The pulse is ignored.
  - `overrun` is set to 1 and stays set until reset.
  - The computation in flight is unaffected.
- `ready` in IDLE is accepted on the same cycle it is sampled, so back-to-back activations are allowed.
- `x` and `w` are used as presented in the cycle `sel` selects them. The block does no operand buffering of its own.

## Timing
- Reset (`reset`=0 at a clock edge):
  - State IDLE.
  - `sel`=0, `y`=0, `done`=0, `busy`=0, `overrun`=0.
  - `acc`=0, `cnt`=0, `bias_r`=0.
- Reset overrides every other event. Reset mid-MAC or mid-ACT aborts without a `done` pulse.
- Cycle numbering for one activation, with `ready` high in cycle T:
  - T+1 .. T+N_IN: MAC, with `sel`=1..N_IN and `busy`=1.
  - T+N_IN+1: ACT, with `sel`=0.
  - T+N_IN+2: OUT, with `done`=1 and the new `y` valid.
- Latency from `ready` to `done` is N_IN+2 cycles. For N_IN=3 that is 5 cycles.
- Next accept: the earliest next `ready` is accepted in cycle T+N_IN+3. Throughput is one activation per N_IN+3 cycles.
- `y` holds its value between `done` pulses.
- `busy` is 1 from T+1 through T+N_IN+2 inclusive.
- `sel` is never nonzero outside MAC.

## Configuration
- `NEURON_RELU_EN`:
  - Defined: a negative saturated result is forced to 0 before it is registered into `y`.
  - Undefined: the saturated signed result passes through unchanged, and `y` may be negative.

## Test plan
- Basic: N_IN=3, `bias`=0, each `x`=0x0100 (1.0) and `w`=0x0200 (2.0), `ready` pulse at T. Required: `sel`=1,2,3 in T+1..T+3, `done`=1 at T+5, `y`=0x0600.
- Negative with bias:
  - Stimulus: `x`=0x0100, `w`=0xFE00 (-2.0) for all inputs, `bias`=0x0080.
  - With `NEURON_RELU_EN`: `y`=0x0000.
  - Without it: `y`=0xFA80 (-5.5).
- Saturation:
  - Positive: `x`=`w`=0x7FFF for all inputs gives `y`=0x7FFF.
  - Negative, without ReLU: `x`=0x7FFF, `w`=0x8000 for all inputs gives `y`=0x8000.
- Overrun: second `ready` pulse at T+2. Required: `overrun`=1 from T+3 onward, a single `done` at T+5, and `y` identical to the basic case.
- Reset mid-operation: `reset`=0 at T+2. Required:
  - At T+3: `sel`=0, `busy`=0, `y`=0.
  - No `done` pulse.
  - A fresh `ready` after reset release completes normally.
- Back-to-back: `ready` at T and T+6. Required: `done` at T+5 and T+11, `overrun` stays 0.
